mux4_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares one 4:1 data mux among four requesters. It owns the 2-bit mux select, grants one requester at a time, and forwards that requester's data to a single downstream channel with a valid/ready handshake. It sits directly in front of the shared 4:1 mux path and replaces static select wiring wherever the output channel is contended.

---
 rtl/mux4_rr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 data mux.
// Grants one requester at a time, drives the mux select and forwards the
// owner's data to a single valid/ready downstream channel.
//
// Optional feature macro: MUX4_ARB_HOLD_LIMIT_EN
//   defined   -> a grant is released after HOLD_LIMIT accepted beats
//   undefined -> the owner keeps the grant until its request drops
//
// Handshake: a beat transfers on a rising clk edge when out_valid and
// out_ready are both high in the cycle before it; out_valid never depends
// on out_ready, and ack_s marks that transfer for the owning requester.

module mux4_rr_arbiter #(
    parameter int WIDTH      = 8,
    parameter int HOLD_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req_s,
    input  logic [4*WIDTH-1:0]   in_s,
    input  logic                 out_ready,
    output logic [3:0]           gnt_s,
    output logic [1:0]           sel_s,
    output logic [WIDTH-1:0]     out_s,
    output logic                 out_valid,
    output logic [3:0]           ack_s,
    output logic                 state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       beat;
    logic       release_now;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LIMIT_B = 8'(HOLD_LIMIT);
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
`endif

    // Current FSM state for checkers: 1 while a requester owns the mux.
    assign state_dbg = (state == GRANT);

    // Data path: the registered select steers the shared mux.
    assign out_s     = in_s[sel_s*WIDTH +: WIDTH];
    assign out_valid = (state == GRANT) && req_s[sel_s];
    assign beat      = out_valid && out_ready;

    // Ack is one-hot on the owner, only in the cycle a beat transfers.
    always_comb begin
        ack_s        = 4'b0000;
        ack_s[sel_s] = beat;
    end

    // Round-robin pick: first set request scanning from ptr upward, mod 4.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!pick_found && req_s[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    // Release when the owner lets go, or when this beat reaches the limit.
    // Both at once still yields a single release.
    always_comb begin
        cnt_inc     = cnt + 8'd1;
        release_now = !req_s[sel_s] || (beat && (cnt_inc == HOLD_LIMIT_B));
    end
`else
    // Release only when the owner lets go; other requesters never preempt.
    always_comb begin
        release_now = !req_s[sel_s];
    end
`endif

    // Arbitration FSM with registered grant, select and priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt_s <= 4'b0000;
            sel_s <= 2'd0;
            ptr   <= 2'd0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            cnt   <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_s <= 4'b0001 << pick_idx;
                        sel_s <= pick_idx;
                        state <= GRANT;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                        cnt   <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // sel_s keeps its value so out_s stays on the last owner.
                        gnt_s <= 4'b0000;
                        ptr   <= sel_s + 2'd1;
                        state <= IDLE;
                    end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                    else if (beat) begin
                        cnt <= cnt_inc;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    gnt_s <= 4'b0000;
                end
            endcase
        end
    end

endmodule
